// File: rtl/spi_core_top_if.sv
// SPI output bundle shared by the button-driven test master and whatever observes it.
// Signal names match the board pin names so constraints map one-to-one.
interface spi_core_top_if;
    logic SCK_LP;
    logic SCK_LN;
    logic SCK_HN;
    logic SCK_HP;
    logic CS;
    logic MOSI;

    modport master (
        output SCK_LP,
        output SCK_LN,
        output SCK_HN,
        output SCK_HP,
        output CS,
        output MOSI
    );

    modport slave (
        input SCK_LP,
        input SCK_LN,
        input SCK_HN,
        input SCK_HP,
        input CS,
        input MOSI
    );
endinterface

// File: rtl/spi_core_top.sv
// Button-driven SPI master: button_0 bumps a payload counter, button_1 sends it MSB first,
// with four SCK flavours so a slave in any SPI mode can sample the same MOSI stream.
module spi_core_top #(
    parameter int DATA_W      = 8,
    parameter int HALF_PERIOD = 4,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2
) (
    input  logic           clk_100,
    input  logic           a_rst,
    input  logic           s_rst,
    input  logic           button_0,
    input  logic           button_1,
    spi_core_top_if.master spi
);

    localparam int BIT_PERIOD = 2 * HALF_PERIOD;
    localparam int CNT_MAX_A  = (BIT_PERIOD > CS_SETUP) ? BIT_PERIOD : CS_SETUP;
    localparam int CNT_MAX    = (CNT_MAX_A > CS_HOLD) ? CNT_MAX_A : CS_HOLD;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronisers and rising-edge detectors (index 0: inc, 1: send)
    // ------------------------------------------------------------------
    logic [1:0] btn_in;
    logic [1:0] meta_q, meta_d;
    logic [1:0] sync_q, sync_d;
    logic [1:0] prev_q, prev_d;
    logic [1:0] pulse;

    assign btn_in = {button_1, button_0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            assign meta_d[gi] = s_rst ? 1'b0 : btn_in[gi];
            assign sync_d[gi] = s_rst ? 1'b0 : meta_q[gi];
            assign prev_d[gi] = s_rst ? 1'b0 : sync_q[gi];
            assign pulse[gi]  = sync_q[gi] & ~prev_q[gi];
        end
    endgenerate

    always_ff @(posedge clk_100 or negedge a_rst) begin
        if (!a_rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame engine
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                cs_q, cs_d;
    logic                mosi_q, mosi_d;
    logic                sck_lp_q, sck_lp_d;
    logic                sck_ln_q, sck_ln_d;
    logic                sck_hn_q, sck_hn_d;
    logic                sck_hp_q, sck_hp_d;

    always_ff @(posedge clk_100 or negedge a_rst) begin
        if (!a_rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            sck_lp_q <= 1'b0;
            sck_ln_q <= 1'b0;
            sck_hn_q <= 1'b1;
            sck_hp_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            cs_q     <= cs_d;
            mosi_q   <= mosi_d;
            sck_lp_q <= sck_lp_d;
            sck_ln_q <= sck_ln_d;
            sck_hn_q <= sck_hn_d;
            sck_hp_q <= sck_hp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q + DATA_W'(pulse[0]);
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        cs_d     = cs_q;
        mosi_d   = mosi_q;
        sck_lp_d = sck_lp_q;
        sck_ln_d = sck_ln_q;
        sck_hn_d = sck_hn_q;
        sck_hp_d = sck_hp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pulse[1]) begin
                    // count_q is the pre-increment value even if button_0 pulses now
                    shift_d = count_q;
                    mosi_d  = count_q[DATA_W-1];
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    cnt_d    = '0;
                    bit_d    = BIT_W'(DATA_W - 1);
                    sck_lp_d = 1'b0;
                    sck_hp_d = 1'b0;
                    sck_ln_d = 1'b1;
                    sck_hn_d = 1'b1;
                    state_d  = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (cnt_q == CNT_W'(BIT_PERIOD - 1)) begin
                    cnt_d = '0;
                    if (bit_q == '0) begin
                        sck_lp_d = 1'b0;
                        sck_ln_d = 1'b0;
                        sck_hn_d = 1'b1;
                        sck_hp_d = 1'b1;
                        state_d  = ST_HOLD;
                    end else begin
                        // MOSI only moves at a bit-period boundary, never mid-bit
                        bit_d    = bit_q - BIT_W'(1);
                        shift_d  = shift_q << 1;
                        mosi_d   = shift_d[DATA_W-1];
                        sck_lp_d = 1'b0;
                        sck_hp_d = 1'b0;
                        sck_ln_d = 1'b1;
                        sck_hn_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(HALF_PERIOD - 1)) begin
                        sck_lp_d = 1'b1;
                        sck_hp_d = 1'b1;
                        sck_ln_d = 1'b0;
                        sck_hn_d = 1'b0;
                    end
                end
            end

            ST_HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Synchronous clear aborts any frame and lands in the same state as a_rst
        if (s_rst) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            shift_d  = '0;
            cnt_d    = '0;
            bit_d    = '0;
            cs_d     = 1'b1;
            mosi_d   = 1'b0;
            sck_lp_d = 1'b0;
            sck_ln_d = 1'b0;
            sck_hn_d = 1'b1;
            sck_hp_d = 1'b1;
        end
    end

    assign spi.CS     = cs_q;
    assign spi.MOSI   = mosi_q;
    assign spi.SCK_LP = sck_lp_q;
    assign spi.SCK_LN = sck_ln_q;
    assign spi.SCK_HN = sck_hn_q;
    assign spi.SCK_HP = sck_hp_q;

endmodule

// File: tb/tb_spi_core_top.sv
// Directed bench for spi_core_top: sends frames via button pulses and checks the
// bits captured on SCK_LP rising / SCK_HN falling edges plus frame timing.
module tb_spi_core_top;

    logic clk_100  = 1'b0;
    logic a_rst    = 1'b1;
    logic s_rst    = 1'b0;
    logic button_0 = 1'b0;
    logic button_1 = 1'b0;

    spi_core_top_if spi_bus ();

    spi_core_top dut (
        .clk_100  (clk_100),
        .a_rst    (a_rst),
        .s_rst    (s_rst),
        .button_0 (button_0),
        .button_1 (button_1),
        .spi      (spi_bus)
    );

    always #5 clk_100 = ~clk_100;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Slave-side observer, sampled on the falling clk edge
    logic       lp_prev    = 1'b0;
    logic       hn_prev    = 1'b1;
    logic       cs_prev    = 1'b1;
    logic [7:0] lp_data    = 8'h00;
    logic [7:0] hn_data    = 8'h00;
    int         lp_rises   = 0;
    int         hn_falls   = 0;
    int         cs_low_cyc = 0;
    int         cs_falls   = 0;

    always @(negedge clk_100) begin
        if (!lp_prev && spi_bus.SCK_LP) begin
            lp_rises <= lp_rises + 1;
            lp_data  <= {lp_data[6:0], spi_bus.MOSI};
        end
        if (hn_prev && !spi_bus.SCK_HN) begin
            hn_falls <= hn_falls + 1;
            hn_data  <= {hn_data[6:0], spi_bus.MOSI};
        end
        if (cs_prev && !spi_bus.CS) cs_falls <= cs_falls + 1;
        if (!spi_bus.CS) cs_low_cyc <= cs_low_cyc + 1;
        lp_prev <= spi_bus.SCK_LP;
        hn_prev <= spi_bus.SCK_HN;
        cs_prev <= spi_bus.CS;
    end

    int s_rises, s_falls, s_cyc, s_cs;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic press(input int which, input int hold = 1);
        if (which == 0) button_0 = 1'b1; else button_1 = 1'b1;
        repeat (hold) tick();
        button_0 = 1'b0;
        button_1 = 1'b0;
        tick();
    endtask

    task automatic sync_clear();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        tick();
    endtask

    task automatic start_frame(input string tag);
        int n;
        s_rises = lp_rises;
        s_falls = hn_falls;
        s_cyc   = cs_low_cyc;
        s_cs    = cs_falls;
        press(1);
        n = 0;
        while (spi_bus.CS !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        check_val({tag, "_cs_start"}, spi_bus.CS, 0);
    endtask

    task automatic finish_frame(input string tag, input logic [7:0] exp_data);
        int n;
        n = 0;
        while (spi_bus.CS !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tick();
        check_val({tag, "_cs_end"}, spi_bus.CS, 1);
        check_val({tag, "_lp_data"}, lp_data, exp_data);
        check_val({tag, "_hn_data"}, hn_data, exp_data);
        check_val({tag, "_lp_rises"}, lp_rises - s_rises, 8);
        check_val({tag, "_hn_falls"}, hn_falls - s_falls, 8);
        check_val({tag, "_cs_cycles"}, cs_low_cyc - s_cyc, 68);
        check_val({tag, "_cs_windows"}, cs_falls - s_cs, 1);
        $display("frame %s: data=0x%02h lp_rises=%0d cs_low=%0d", tag, lp_data,
                 lp_rises - s_rises, cs_low_cyc - s_cyc);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_cs"},   spi_bus.CS, 1);
        check_val({tag, "_mosi"}, spi_bus.MOSI, 0);
        check_val({tag, "_lp"},   spi_bus.SCK_LP, 0);
        check_val({tag, "_ln"},   spi_bus.SCK_LN, 0);
        check_val({tag, "_hn"},   spi_bus.SCK_HN, 1);
        check_val({tag, "_hp"},   spi_bus.SCK_HP, 1);
    endtask

    initial begin
        // Asynchronous reset with no clock edge involved
        #2 a_rst = 1'b0;
        #1 check_idle("arst");
        tick();
        tick();
        a_rst = 1'b1;
        repeat (5) tick();
        check_idle("idle");

        start_frame("zero");
        finish_frame("zero", 8'h00);

        press(0);
        repeat (4) tick();
        start_frame("one");
        finish_frame("one", 8'h01);

        sync_clear();
        for (int i = 0; i < 256; i++) press(0);
        repeat (4) tick();
        start_frame("wrap");
        finish_frame("wrap", 8'h00);

        sync_clear();
        for (int i = 0; i < 3; i++) press(0);
        repeat (4) tick();
        start_frame("three");
        finish_frame("three", 8'h03);

        // Second send request during a frame must be dropped
        start_frame("dup");
        repeat (20) tick();
        press(1);
        finish_frame("dup", 8'h03);
        repeat (10) tick();
        check_val("dup_no_second_frame", cs_falls - s_cs, 1);
        check_val("dup_cs_idle", spi_bus.CS, 1);

        // Increment during a frame affects only the next frame
        start_frame("midinc");
        repeat (20) tick();
        press(0);
        finish_frame("midinc", 8'h03);
        start_frame("after_inc");
        finish_frame("after_inc", 8'h04);

        // Synchronous clear in the middle of SHIFT
        start_frame("srst");
        repeat (20) tick();
        s_rst = 1'b1;
        tick();
        check_idle("srst_mid");
        s_rst = 1'b0;
        repeat (4) tick();
        start_frame("post_srst");
        finish_frame("post_srst", 8'h00);

        // Held button gives a single increment
        press(0, 10);
        repeat (4) tick();
        start_frame("held");
        finish_frame("held", 8'h01);

        // Asynchronous reset mid-frame, checked before the next clock edge
        start_frame("arst_mid");
        repeat (20) tick();
        #1 a_rst = 1'b0;
        #1 check_idle("arst_mid");
        tick();
        a_rst = 1'b1;
        repeat (4) tick();
        start_frame("post_arst");
        finish_frame("post_arst", 8'h00);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
